// File: rtl/mem_subsystem_rr_pkg.sv
// Shared types for the round-robin memory subsystem: coherency and FSM
// encodings plus the per-block coherency transition function.
package memsub_pkg;

  typedef enum logic [1:0] {
    COH_I = 2'b00,
    COH_M = 2'b01,
    COH_S = 2'b10
  } coherency_t;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } fsm_t;

  // Writes always own the block; reads promote I to S and leave S/M alone.
  function automatic coherency_t next_coh(input coherency_t state, input logic is_write);
    if (is_write) return COH_M;
    if (state == COH_I) return COH_S;
    return state;
  endfunction

endpackage

// File: rtl/mem_subsystem_rr_arbiter.sv
// True round-robin arbiter: the first requester at or after the pointer wins,
// and the pointer moves to one past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_pos;
  logic          w_found;

  // Scan from the pointer, wrapping modulo N, and pick the first request.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    w_found     = 1'b0;
    w_pos       = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = IW'((int'(r_ptr) + i) % N);
      if (!w_found && req_i[w_pos]) begin
        w_found        = 1'b1;
        grant_o[w_pos] = 1'b1;
        grant_idx_o    = w_pos;
      end
    end
  end

  // Rotate the pointer past the port that was just granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (advance_i) begin
      r_ptr <= (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
    end
  end

endmodule

// File: rtl/mem_subsystem_rr.sv
// N-port shared memory with round-robin arbitration, out-of-range error
// reporting and a post-reset initialisation sweep (data[i] = i+1).
// Optional: define MEMSUB_COH_EN to add per-block I/S/M coherency tracking;
// without it coh_o stays 2'b00 and data path/timing are unchanged.
//
// Handshake: a port raises req with we/addr/wdata and holds them stable until
// it sees its resp_o bit (a one-cycle pulse, qualified by err_o). In the cycle
// after the pulse it drops req or presents a new transaction; a req still high
// is served again. Each transaction takes IDLE -> ACCESS -> RESP (3 cycles).
module mem_subsystem_rr
  import memsub_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 50
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
  output logic [NUM_PORTS*DATA_W-1:0] rdata_o,
  output logic [NUM_PORTS-1:0]        resp_o,
  output logic [NUM_PORTS-1:0]        err_o,
  output logic [1:0]                  coh_o,
  output logic                        busy_o,
  output logic [1:0]                  dbg_state_o
);

  localparam int IW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  fsm_t                 r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [IW-1:0]        r_gnt;
  logic [NUM_PORTS-1:0] r_gnt_oh;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [NUM_PORTS-1:0] r_resp;
  logic [NUM_PORTS-1:0] r_err;
  logic [1:0]           r_coh;
  logic [DATA_W-1:0]    r_rdata [NUM_PORTS];
  logic [DATA_W-1:0]    r_mem   [DEPTH];

  logic [NUM_PORTS-1:0] w_gnt_oh;
  logic [IW-1:0]        w_gnt_idx;
  logic                 w_advance;
  logic                 w_oor;
  logic [IDX_W-1:0]     w_aidx;
  coherency_t           w_coh_next;

  assign w_advance = (r_state == ST_IDLE) && (|req_i);
  assign w_oor     = {1'b0, r_addr} >= DEPTH_L;
  assign w_aidx    = r_addr[IDX_W-1:0];

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .advance_i   (w_advance),
    .grant_o     (w_gnt_oh),
    .grant_idx_o (w_gnt_idx)
  );

`ifdef MEMSUB_COH_EN
  coherency_t r_cstate [DEPTH];

  assign w_coh_next = next_coh(r_cstate[w_aidx], r_we);

  // Coherency array: cleared to I by the sweep, updated by in-range accesses.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_cstate[r_idx] <= COH_I;
    end else if (r_state == ST_ACCESS && !w_oor) begin
      r_cstate[w_aidx] <= w_coh_next;
    end
  end
`else
  assign w_coh_next = COH_I;
`endif

  // Data array: sweep writes i+1, in-range writes store the latched data.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_idx] <= DATA_W'(r_idx) + DATA_W'(1);
    end else if (r_state == ST_ACCESS && r_we && !w_oor) begin
      r_mem[w_aidx] <= r_wdata;
    end
  end

  // Control FSM: sweep, grant/latch, access, then one-cycle response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_INIT;
      r_idx    <= '0;
      r_gnt    <= '0;
      r_gnt_oh <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_resp   <= '0;
      r_err    <= '0;
      r_coh    <= 2'b00;
      for (int p = 0; p < NUM_PORTS; p++) r_rdata[p] <= '0;
    end else begin
      r_resp <= '0;
      r_err  <= '0;
      case (r_state)
        ST_INIT: begin
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_IDLE: begin
          if (w_advance) begin
            r_gnt    <= w_gnt_idx;
            r_gnt_oh <= w_gnt_oh;
            r_we     <= we_i[w_gnt_idx];
            r_addr   <= addr_i[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
            r_wdata  <= wdata_i[int'(w_gnt_idx)*DATA_W +: DATA_W];
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_resp  <= r_gnt_oh;
          r_state <= ST_RESP;
          if (w_oor) begin
            r_err          <= r_gnt_oh;
            r_rdata[r_gnt] <= '0;
            r_coh          <= COH_I;
          end else begin
            r_coh <= w_coh_next;
            if (!r_we) r_rdata[r_gnt] <= r_mem[w_aidx];
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdata
    assign rdata_o[p*DATA_W +: DATA_W] = r_rdata[p];
  end

  assign resp_o      = r_resp;
  assign err_o       = r_err;
  assign coh_o       = r_coh;
  assign busy_o      = (r_state == ST_INIT);
  assign dbg_state_o = r_state;

endmodule

// File: doc/mem_subsystem_rr.md
Name: mem_subsystem_rr

Overview:
- Parametrised successor of the 4-port shared memory subsystem.
- N processor ports share one single-ported data array through a true round-robin arbiter with a strict req/resp handshake.
- Adds per-block I/S/M coherency tracking, out-of-range error reporting and a sequential post-reset initialisation sweep.
- Sits between the processor request ports and the shared data store.

Parameters:
- NUM_PORTS, 4, number of processor ports (2..16).
- DATA_W, 16, data word width in bits.
- ADDR_W, 14, address width per port.
- DEPTH, 50, number of array entries (block index space, DEPTH <= 2**ADDR_W).

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_PORTS  per-port request level.
- we_i  in  NUM_PORTS  per-port 1=write, 0=read.
- addr_i  in  NUM_PORTS*ADDR_W  packed addresses, port p at [p*ADDR_W +: ADDR_W].
- wdata_i  in  NUM_PORTS*DATA_W  packed write data.
- rdata_o  out  NUM_PORTS*DATA_W  packed read data, per port, held until that port's next response.
- resp_o  out  NUM_PORTS  one-hot single-cycle completion pulse.
- err_o  out  NUM_PORTS  qualifies resp_o: address out of range.
- coh_o  out  2  coherency state of the block, valid with any resp_o.
- busy_o  out  1  high during the init sweep.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - FSM = INIT, sweep index 0, busy_o=1.
  - resp_o, err_o, rdata_o, coh_o all 0.
  - RR pointer = port 0 highest priority.
- FSM states: INIT, IDLE, ACCESS, RESP.
- INIT:
  - One entry per cycle: data[i]=i+1, state[i]=I.
  - Moves to IDLE after entry DEPTH-1 and clears busy_o.
  - Requests are ignored, not lost; they are served once IDLE is reached.
- IDLE:
  - If any req_i is set, grant the first requesting port at or after the RR pointer, wrapping modulo NUM_PORTS.
  - Latch that port's we, addr and wdata; go to ACCESS.
  - The RR pointer becomes grant+1 (wrapping).
  - If no request, stay in IDLE.
- ACCESS, out of range (addr >= DEPTH):
  - No array or state change; err_o[g]=1 and rdata for port g = 0.
- ACCESS, write: data[addr] <= wdata; state -> M.
- ACCESS, read:
  - rdata for port g <= data[addr].
  - State transitions: I->S, S->S, M->M.
- ACCESS, on exit: coh_o <= post-access state; go to RESP.
- RESP:
  - resp_o[g]=1 for exactly this cycle; err_o valid alongside it.
  - Return to IDLE. All resp_o/err_o bits are 0 in every other state.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees resp_o.
  - It must drop req or present a new transaction in the cycle after RESP.
  - A req held high is served again as a new transaction.
- Latency and throughput:
  - resp_o is high 2 cycles after the IDLE edge that samples req.
  - Throughput is one transaction per 3 cycles.
- Simultaneous requests: served one per transaction in RR order. With all ports requesting, no port waits more than NUM_PORTS transactions.
- req dropped before grant: no effect. Inputs for an ungranted port are don't-care.
- Reset mid-operation:
  - Any in-flight access is abandoned and resp_o is forced to 0 immediately.
  - The FSM re-enters INIT and the whole array is re-swept.

Optional Feature:
- MEMSUB_COH_EN defined: the coherency state array and the transitions above are implemented; coh_o reports the state.
- Not defined: no state array, coh_o tied to 2'b00, and INIT writes data only. Data path and timing are unchanged.

Decomposition:
- Package memsub_pkg holds:
  - coherency_t enum (I=2'b00, M=2'b01, S=2'b10).
  - fsm_t enum (INIT, IDLE, ACCESS, RESP).
  - Helper function next_coh(state, is_write).
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, advance strobe.
  - Outputs: one-hot grant and grant index.
  - Owns the rotating pointer; reset to port 0.

Test Plan:
- After reset: busy_o high DEPTH cycles. Reads of addr 0, 7 and 49 return 1, 8 and 50. coh_o=I->S on first read (with MEMSUB_COH_EN).
- Port 2 writes 16'hBEEF to addr 5, then port 0 reads addr 5 -> rdata for port 0 = 16'hBEEF, coh_o=M, resp_o=4'b0001, 2 cycles after the sample edge.
- All 4 ports request continuously from reset -> resp_o sequence 0001, 0010, 0100, 1000, 0001. The pulse is at most one-hot every 3 cycles.
- Port 1 reads addr 60 (DEPTH=50) -> resp_o[1]=1 with err_o[1]=1 and rdata for port 1 = 0. A later read of addr 49 still returns 50.
- reset_n pulsed low during ACCESS of a write to addr 3 -> no resp_o. After re-init, addr 3 reads 4 with coh I->S.
- Build without MEMSUB_COH_EN -> coh_o remains 0 across writes and reads; data results are identical to the above.
